// File: rtl/shift_seq_pkg.sv
// Shared types and control-pin encodings for the shift register sequencer.
package shift_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_PAR,
        ST_DONE
    } state_t;

    // Mode encodings for the universal shift register's s[1:0] pins.
    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_LEFT  = 2'b01;
    localparam logic [1:0] S_RIGHT = 2'b10;

endpackage

// File: rtl/shift_seq_bitcnt.sv
// Shift counter for the sequencer.
// Synchronous clear overrides enable; tc flags the last of WIDTH shifts.
module shift_seq_bitcnt #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_reg_seq_ctrl.sv
// Job sequencer driving an external universal shift register (TX load/shift-out, RX shift-in).
// Define SHIFT_SEQ_PARITY_EN to add a trailing even-parity bit cycle and the par_err port.
module shift_reg_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic             job_rx,
    input  logic             job_left,
    input  logic [WIDTH-1:0] job_data,
    input  logic             abort,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] done_data,
`ifdef SHIFT_SEQ_PARITY_EN
    output logic             par_err,
`endif
    output logic             reg_ld,
    output logic [1:0]       reg_s,
    output logic [WIDTH-1:0] reg_din,
    output logic             reg_sin,
    input  logic [WIDTH-1:0] reg_q
);

    state_t state, state_nxt;
    logic   job_rx_q, job_left_q;
    logic   accept, cnt_clr, cnt_en, cnt_tc;
`ifdef SHIFT_SEQ_PARITY_EN
    logic   par_bit_q, par_err_q, par_sample;
`endif

    shift_seq_bitcnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bitcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .tc      (cnt_tc)
    );

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt  = state;
        job_ready  = 1'b0;
        accept     = 1'b0;
        reg_ld     = 1'b0;
        reg_s      = S_HOLD;
        reg_din    = reg_q;
        reg_sin    = 1'b0;
        ser_out    = 1'b0;
        ser_valid  = 1'b0;
        done_valid = 1'b0;
        done_data  = '0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
        par_sample = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                // Gated by reset_n so nothing is accepted or loaded while reset is held.
                job_ready = reset_n;
                if (job_valid && reset_n) begin
                    accept = 1'b1;
                    if (job_rx) begin
                        state_nxt = ST_SHIFT;
                        cnt_clr   = 1'b1;
                    end else begin
                        state_nxt = ST_LOAD;
                        reg_ld    = 1'b1;
                        reg_din   = job_data;
                    end
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_SHIFT;
                    cnt_clr   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    reg_s     = job_left_q ? S_LEFT : S_RIGHT;
                    reg_sin   = job_rx_q & ser_in;
                    ser_out   = job_left_q ? reg_q[WIDTH-1] : reg_q[0];
                    ser_valid = 1'b1;
                    cnt_en    = 1'b1;
                    if (cnt_tc) begin
`ifdef SHIFT_SEQ_PARITY_EN
                        state_nxt = ST_PAR;
`else
                        state_nxt = ST_DONE;
`endif
                    end
                end
            end
`ifdef SHIFT_SEQ_PARITY_EN
            ST_PAR: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    ser_valid  = 1'b1;
                    ser_out    = ~job_rx_q & par_bit_q;
                    par_sample = job_rx_q;
                    state_nxt  = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                // abort suppresses the handshake so a concurrent done_ready never completes it.
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    done_valid = 1'b1;
                    done_data  = reg_q;
                    if (done_ready) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            job_rx_q   <= 1'b0;
            job_left_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                job_rx_q   <= job_rx;
                job_left_q <= job_left;
            end
        end
    end

`ifdef SHIFT_SEQ_PARITY_EN
    // TX parity is taken from the payload at accept; the register is empty by PAR time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
        end else if (accept) begin
            par_bit_q <= ^job_data;
            par_err_q <= 1'b0;
        end else if (par_sample) begin
            par_err_q <= ser_in ^ (^reg_q);
        end
    end

    assign par_err = done_valid & par_err_q;
`endif

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Self-checking bench: random TX/RX jobs against a reference model, queue-based scoreboard.
module tb_shift_reg_seq_ctrl;

    localparam int W  = 4;
    localparam int CW = 3;
`ifdef SHIFT_SEQ_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         job_valid, job_ready, job_rx, job_left;
    logic [W-1:0] job_data;
    logic         abort, ser_in, ser_out, ser_valid;
    logic         done_valid, done_ready;
    logic [W-1:0] done_data;
    logic         reg_ld, reg_sin;
    logic [1:0]   reg_s;
    logic [W-1:0] reg_din;
    logic [W-1:0] reg_q = '0;
`ifdef SHIFT_SEQ_PARITY_EN
    logic         par_err;
    logic         par_wrong = 1'b0;
`endif

    shift_reg_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_rx     (job_rx),
        .job_left   (job_left),
        .job_data   (job_data),
        .abort      (abort),
        .ser_in     (ser_in),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_data  (done_data),
`ifdef SHIFT_SEQ_PARITY_EN
        .par_err    (par_err),
`endif
        .reg_ld     (reg_ld),
        .reg_s      (reg_s),
        .reg_din    (reg_din),
        .reg_sin    (reg_sin),
        .reg_q      (reg_q)
    );

    always #5 clk = ~clk;

    // The external universal shift register being sequenced.
    always @(posedge clk) begin
        if (reg_ld || reg_s == 2'b00 || reg_s == 2'b11) reg_q <= reg_din;
        else if (reg_s == 2'b01) reg_q <= {reg_q[W-2:0], reg_sin};
        else reg_q <= {reg_sin, reg_q[W-1:1]};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct { logic chk; logic bitv; } ser_exp_t;
    typedef struct { logic [W-1:0] data; logic perr; } done_exp_t;
    ser_exp_t  ser_q[$];
    done_exp_t done_q[$];
    ser_exp_t  mon_s;
    done_exp_t mon_d;

    // Monitor: pops an expectation whenever the DUT presents a bit strobe or a completed result.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ser_valid) begin
                check("ser_expected", 32'(ser_q.size() != 0), 1);
                if (ser_q.size() != 0) begin
                    mon_s = ser_q.pop_front();
                    if (mon_s.chk) check("ser_out", ser_out, mon_s.bitv);
                end
            end
            if (done_valid && done_ready) begin
                check("done_expected", 32'(done_q.size() != 0), 1);
                if (done_q.size() != 0) begin
                    mon_d = done_q.pop_front();
                    check("done_data", done_data, mon_d.data);
`ifdef SHIFT_SEQ_PARITY_EN
                    check("par_err", par_err, mon_d.perr);
`endif
                end
            end
        end
    end

    logic [W-1:0] exp_reg = '0;
    int           acc_cyc;

    task automatic accept_job(input logic rx, input logic left, input logic [W-1:0] data);
        int n = 0;
        job_rx = rx; job_left = left; job_data = data; job_valid = 1'b1;
        @(negedge clk);
        while (!job_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 64), 1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic run_shifts(input logic rx, input logic left, input logic [W-1:0] data,
                              input logic [W-1:0] bits, input int kill_at, input logic use_rst,
                              output logic killed);
        logic [W-1:0] word;
        logic         sin;
        done_exp_t    d;
        killed = 1'b0;
        if (!rx) begin
            exp_reg = data;
            @(posedge clk); #1;
        end
        for (int i = 0; i < W; i++) begin
            ser_in = rx ? bits[i] : 1'($urandom);
            if (i == kill_at) begin
                if (use_rst) begin
                    reset_n = 1'b0; #1;
                    check("rst_ser_valid", ser_valid, 0);
                    check("rst_ser_out", ser_out, 0);
                    check("rst_ld", reg_ld, 0);
                    check("rst_s", reg_s, 0);
                    check("rst_sin", reg_sin, 0);
                    check("rst_done_valid", done_valid, 0);
                    check("rst_din", reg_din, reg_q);
                    @(posedge clk); #1;
                    check("rst_reg_hold", reg_q, exp_reg);
                    reset_n = 1'b1; #1;
                    check("rst_ready", job_ready, 1);
                end else begin
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    check("abort_ready", job_ready, 1);
                    check("abort_done_valid", done_valid, 0);
                    check("abort_reg", reg_q, exp_reg);
                    @(posedge clk); #1;
                    check("abort_reg_hold", reg_q, exp_reg);
                end
                killed = 1'b1;
                return;
            end
            ser_q.push_back('{chk: 1'b1, bitv: left ? (rx ? exp_reg[W-1] : data[W-1-i])
                                                    : (rx ? exp_reg[0]   : data[i])});
            check("busy_ready", job_ready, 0);
            sin = rx ? bits[i] : 1'b0;
            exp_reg = left ? {exp_reg[W-2:0], sin} : {sin, exp_reg[W-1:1]};
            @(posedge clk); #1;
        end
        word = '0;
        for (int i = 0; i < W; i++) begin
            if (rx) word[left ? (W - 1 - i) : i] = bits[i];
        end
        d.data = word;
        d.perr = 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
        if (rx) begin
            ser_in = par_wrong ? ~(^word) : 1'($urandom);
            d.perr = (ser_in != ^word);
            ser_q.push_back('{chk: 1'b0, bitv: 1'b0});
        end else begin
            ser_q.push_back('{chk: 1'b1, bitv: ^data});
        end
        check("busy_ready_par", job_ready, 0);
        @(posedge clk); #1;
`endif
        done_q.push_back(d);
    endtask

    task automatic finish_job(input int exp_lat);
        int n = 0;
        int hold;
        @(negedge clk);
        while (!done_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(n < 64), 1);
        check("latency", cyc - acc_cyc, exp_lat);
        if (!done_ready) begin
            hold = $urandom_range(0, 3);
            for (int k = 0; k <= hold; k++) begin
                @(posedge clk); #1;
                check("done_hold", done_valid, 1);
            end
            done_ready = 1'b1;
        end
        @(posedge clk); #1;
        done_ready = 1'b0;
        check("done_release", done_valid, 0);
    endtask

    task automatic run_job(input logic rx, input logic left, input logic [W-1:0] data,
                           input logic [W-1:0] bits, input int kill_at, input logic use_rst);
        logic killed;
        accept_job(rx, left, data);
        run_shifts(rx, left, data, bits, kill_at, use_rst, killed);
        if (!killed) finish_job(W + 1 + (rx ? 0 : 1) + PAR);
    endtask

    initial begin
        int a0;
        reset_n = 1'b0; job_valid = 1'b0; job_rx = 1'b0; job_left = 1'b0; job_data = '0;
        abort = 1'b0; ser_in = 1'b0; done_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ser_valid", ser_valid, 0);
        check("reset_done_valid", done_valid, 0);
        check("reset_ld", reg_ld, 0);
        check("reset_s", reg_s, 0);
        check("reset_din", reg_din, reg_q);
        reset_n = 1'b1; #1;
        check("reset_ready", job_ready, 1);

        // TX left 1011, then RX right 1,1,0,0.
        run_job(1'b0, 1'b1, 4'b1011, '0, -1, 1'b0);
        run_job(1'b1, 1'b0, '0, 4'b0011, -1, 1'b0);
        // Abort on the second shift cycle, TX and RX.
        run_job(1'b0, 1'b1, 4'b1101, '0, 1, 1'b0);
        run_job(1'b1, 1'b1, '0, 4'b1010, 1, 1'b0);

        // Back-to-back: second request waits until the cycle after DONE.
        done_ready = 1'b1;
        accept_job(1'b0, 1'b1, 4'b1001);
        a0 = acc_cyc;
        job_rx = 1'b0; job_left = 1'b0; job_data = 4'b0110; job_valid = 1'b1;
        begin
            logic killed;
            run_shifts(1'b0, 1'b1, 4'b1001, '0, -1, 1'b0, killed);
            finish_job(W + 2 + PAR);
            done_ready = 1'b1;
            accept_job(1'b0, 1'b0, 4'b0110);
            check("b2b_accept_cycle", acc_cyc - a0, W + 3 + PAR);
            run_shifts(1'b0, 1'b0, 4'b0110, '0, -1, 1'b0, killed);
            finish_job(W + 2 + PAR);
        end
        done_ready = 1'b0;

        // Asynchronous reset mid-shift, then a clean job.
        run_job(1'b0, 1'b0, 4'b1100, '0, 2, 1'b1);
        run_job(1'b0, 1'b0, 4'b1010, '0, -1, 1'b0);

`ifdef SHIFT_SEQ_PARITY_EN
        run_job(1'b0, 1'b1, 4'b0111, '0, -1, 1'b0);
        par_wrong = 1'b1;
        run_job(1'b1, 1'b0, '0, 4'b0101, -1, 1'b0);
        par_wrong = 1'b0;
`endif

        for (int j = 0; j < 40; j++) begin
            run_job(1'($urandom), 1'($urandom), W'($urandom), W'($urandom),
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W - 1)) : -1, 1'b0);
        end

        repeat (2) @(posedge clk);
        check("ser_q_drained", ser_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
